kp_scan: RTL and testbench
==========================

Name: kp_scan

Overview:
- Keypad front end for the matrix keypad.
- Drives the active-low column lines one at a time and synchronizes the raw active-low row inputs.
- Debounces press and release, then presents a stable column/row pair plus press/held indications to the downstream key decoder (kpc/kpr → num, kphit).
- Sits between the FPGA keypad pins and the decoder.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven before the scanner advances; legal minimum is 4.
- DEBOUNCE_CYC, 20000: consecutive stable cycles needed to accept a press or a release; legal minimum is 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; one clock, reset is asynchronous and active-low
- kpr_raw  input  4  raw row pins, active low, asynchronous to clk
- kpc  output  4  column drive to keypad and decoder, active low, exactly one bit low
- kpr  output  4  debounced row to decoder, active low; 4'b1111 when no accepted key
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high from press acceptance until release acceptance

Behaviour:
- Reset values: kpc = 4'b1110, kpr = 4'b1111, key_valid = 0, key_held = 0, state SCAN, all counters 0, synchronizer flops 4'b1111.
- Input synchronization: kpr_raw passes through a 2-FF synchronizer to form rs. All decisions use rs, so a pin change is seen 2 cycles later.
- Counters: div_cnt is 0..SCAN_DIV-1; db_cnt is 0..DEBOUNCE_CYC-1. Widths use $clog2, and neither counter exceeds its terminal value.
- State SCAN:
  - div_cnt increments every cycle and decisions are taken only at the terminal count, SCAN_DIV-1.
  - At terminal count, if rs has exactly one zero bit: latch row_lat = rs, hold kpc, set db_cnt = 0, go to PRESS_DB.
  - Otherwise (rs all ones, or two or more zeros, i.e. multi-key): rotate kpc left cyclically (1110→1101→1011→0111→1110) and set div_cnt = 0.
- State PRESS_DB:
  - If rs != row_lat: go to SCAN with div_cnt = 0 and kpc unchanged, so the same column is rescanned.
  - Else if db_cnt == DEBOUNCE_CYC-1: go to HELD. In that same transition cycle key_valid = 1 (registered, for exactly one cycle), key_held = 1 and kpr = row_lat.
  - Else increment db_cnt.
- State HELD:
  - kpc is frozen and kpr = row_lat.
  - If rs == 4'b1111: set db_cnt = 0 and go to RELEASE_DB.
  - rs changing to a different non-idle pattern (key roll) is ignored until full release.
- State RELEASE_DB:
  - kpr stays at row_lat and key_held stays 1.
  - If rs != 4'b1111: go back to HELD with no new key_valid.
  - Else if db_cnt == DEBOUNCE_CYC-1: go to SCAN. On that edge key_held = 0, kpr = 4'b1111, kpc rotates to the next column and div_cnt = 0.
  - Else increment db_cnt.
- Invariants:
  - key_valid only pulses on the PRESS_DB→HELD edge.
  - kpc changes only in SCAN at terminal count or on the RELEASE_DB→SCAN edge.
  - kpc is never 4'b1111 and never has more than one zero.
- Latency: a stable press on the driven column asserts key_valid at most SCAN_DIV + DEBOUNCE_CYC + 2 cycles after the pin change, plus up to 3·SCAN_DIV if another column is being driven.
- Reset mid-operation (any state): immediate return to reset values. No key_valid pulse is generated by reset or on the first cycle after it.

Decomposition:
- Shared package kp_pkg:
  - state enum kp_state_t {SCAN, PRESS_DB, HELD, RELEASE_DB}
  - constant KP_IDLE = 4'b1111
  - constant KP_COL0 = 4'b1110
  - function kp_onecold(logic [3:0]) returning true when exactly one bit is zero
- Sub-module kp_sync2: parameterized-width 2-FF synchronizer. Its reset is asynchronous active-low and sets all flops to ones.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8):
- Reset, rows idle 40 cycles → kpc steps 1110,1101,1011,0111,1110 every 4 cycles; kpr = 1111; key_valid never asserts.
- Hold kpr_raw = 4'b1011 only while kpc = 4'b1101, then keep it → kpc freezes at 1101; one key_valid pulse 8 cycles after detection; key_held = 1; kpr = 1011.
- Bounce: kpr_raw = 1011 for 5 cycles, 1111 for 1 cycle, then stable → no key_valid during the bounce; a single pulse after 8 stable cycles from restart.
- Release with 3-cycle glitch back to 1011 mid-debounce → stays held with no second pulse. After 8 clean idle cycles: key_held = 0, kpr = 1111, kpc advances to 1011.
- Two rows low simultaneously (kpr_raw = 1001) → no press accepted; scan keeps rotating.
- Assert reset_n = 0 while in HELD → kpc = 1110, kpr = 1111, key_held = 0 asynchronously; no key_valid after release of reset while rows are idle.

Source files
------------

// File: rtl/kp_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, idle/column
// encodings, and small pattern helpers on active-low 4-bit vectors.
package kp_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } kp_state_t;

  localparam logic [3:0] KP_IDLE = 4'b1111;
  localparam logic [3:0] KP_COL0 = 4'b1110;

  // True when exactly one of the four active-low lines is asserted.
  function automatic logic kp_onecold(input logic [3:0] v);
    logic [2:0] zeros;
    zeros = 3'd0;
    for (int i = 0; i < 4; i++) begin
      zeros = zeros + {2'b00, ~v[i]};
    end
    return (zeros == 3'd1);
  endfunction

  function automatic logic [3:0] kp_rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for active-low pin inputs; resets to all ones so an
// idle (released) pattern is presented while reset is asserted.
module kp_sync2 #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/kp_scan.sv
// Matrix keypad front end: walks a single low column across the keypad,
// debounces press and release on the synchronized rows, and presents kpc/kpr.
module kp_scan
  import kp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr_raw,
  output logic [3:0] kpc,
  output logic [3:0] kpr,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  logic [3:0]       w_rs;
  kp_state_t        r_state;
  kp_state_t        w_nextState;
  logic [DIV_W-1:0] r_divCnt;
  logic [DB_W-1:0]  r_dbCnt;
  logic [3:0]       r_rowLat;
  logic [3:0]       r_kpc;
  logic [3:0]       r_kpr;
  logic             r_keyValid;
  logic             r_keyHeld;

  logic w_divTerm;
  logic w_dbTerm;
  logic w_rsIdle;
  logic w_rsMatch;
  logic w_rsOneCold;

  logic w_divInc;
  logic w_divClr;
  logic w_rotate;
  logic w_latch;
  logic w_dbClr;
  logic w_dbInc;
  logic w_accept;
  logic w_release;

  kp_sync2 #(.W(4)) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (kpr_raw),
    .o_q     (w_rs)
  );

  assign w_divTerm   = (r_divCnt == DIV_LAST);
  assign w_dbTerm    = (r_dbCnt == DB_LAST);
  assign w_rsIdle    = (w_rs == KP_IDLE);
  assign w_rsMatch   = (w_rs == r_rowLat);
  assign w_rsOneCold = kp_onecold(w_rs);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Multi-key patterns never leave SCAN; a key roll while held waits for full release.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SCAN: begin
        if (w_divTerm && w_rsOneCold) begin
          w_nextState = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!w_rsMatch) begin
          w_nextState = SCAN;
        end else if (w_dbTerm) begin
          w_nextState = HELD;
        end
      end
      HELD: begin
        if (w_rsIdle) begin
          w_nextState = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (!w_rsIdle) begin
          w_nextState = HELD;
        end else if (w_dbTerm) begin
          w_nextState = SCAN;
        end
      end
      default: w_nextState = SCAN;
    endcase
  end

  always_comb begin
    w_divInc  = 1'b0;
    w_divClr  = 1'b0;
    w_rotate  = 1'b0;
    w_latch   = 1'b0;
    w_dbClr   = 1'b0;
    w_dbInc   = 1'b0;
    w_accept  = 1'b0;
    w_release = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_divTerm) begin
          w_divClr = 1'b1;
          if (w_rsOneCold) begin
            w_latch = 1'b1;
            w_dbClr = 1'b1;
          end else begin
            w_rotate = 1'b1;
          end
        end else begin
          w_divInc = 1'b1;
        end
      end
      PRESS_DB: begin
        if (!w_rsMatch) begin
          w_divClr = 1'b1;
        end else if (w_dbTerm) begin
          w_accept = 1'b1;
        end else begin
          w_dbInc = 1'b1;
        end
      end
      HELD: begin
        if (w_rsIdle) begin
          w_dbClr = 1'b1;
        end
      end
      RELEASE_DB: begin
        if (w_rsIdle) begin
          if (w_dbTerm) begin
            w_release = 1'b1;
            w_rotate  = 1'b1;
            w_divClr  = 1'b1;
          end else begin
            w_dbInc = 1'b1;
          end
        end
      end
      default: begin
        w_divClr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_divCnt <= '0;
      r_dbCnt  <= '0;
      r_rowLat <= KP_IDLE;
      r_kpc    <= KP_COL0;
    end else begin
      if (w_divClr) begin
        r_divCnt <= '0;
      end else if (w_divInc) begin
        r_divCnt <= r_divCnt + 1'b1;
      end
      if (w_dbClr) begin
        r_dbCnt <= '0;
      end else if (w_dbInc) begin
        r_dbCnt <= r_dbCnt + 1'b1;
      end
      if (w_latch) begin
        r_rowLat <= w_rs;
      end
      if (w_rotate) begin
        r_kpc <= kp_rotl(r_kpc);
      end
    end
  end

  // Decoder-facing outputs are registered so key_valid is a clean single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kpr      <= KP_IDLE;
      r_keyValid <= 1'b0;
      r_keyHeld  <= 1'b0;
    end else begin
      r_keyValid <= w_accept;
      if (w_accept) begin
        r_keyHeld <= 1'b1;
        r_kpr     <= r_rowLat;
      end else if (w_release) begin
        r_keyHeld <= 1'b0;
        r_kpr     <= KP_IDLE;
      end
    end
  end

  assign kpc       = r_kpc;
  assign kpr       = r_kpr;
  assign key_valid = r_keyValid;
  assign key_held  = r_keyHeld;

endmodule

// File: tb/tb_kp_scan.sv
// Directed bench for kp_scan with SCAN_DIV=4, DEBOUNCE_CYC=8: idle scan,
// press with bounce, glitchy release, multi-key rejection and reset in HELD.
module tb_kp_scan;

  typedef struct {
    int         cycles;
    logic [3:0] raw;
    logic [3:0] expKpc;
    logic [3:0] expKpr;
    logic       expValid;
    logic       expHeld;
  } seg_t;

  logic       clk;
  logic       resetN;
  logic [3:0] kprRaw;
  logic [3:0] kpc;
  logic [3:0] kpr;
  logic       keyValid;
  logic       keyHeld;

  int checks;
  int errors;
  int edgeNum;

  seg_t       segTab [0:14];
  logic [3:0] cols   [0:3];

  kp_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk       (clk),
    .reset_n   (resetN),
    .kpr_raw   (kprRaw),
    .kpc       (kpc),
    .kpr       (kpr),
    .key_valid (keyValid),
    .key_held  (keyHeld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] raw);
    kprRaw = raw;
    @(posedge clk);
    #1;
    edgeNum++;
  endtask

  task automatic checkAll(input string tag, input logic [3:0] eKpc, input logic [3:0] eKpr,
                          input logic eValid, input logic eHeld);
    checkOutput($sformatf("%s kpc e%0d", tag, edgeNum), kpc, eKpc);
    checkOutput($sformatf("%s kpr e%0d", tag, edgeNum), kpr, eKpr);
    checkOutput($sformatf("%s valid e%0d", tag, edgeNum), {3'b000, keyValid}, {3'b000, eValid});
    checkOutput($sformatf("%s held e%0d", tag, edgeNum), {3'b000, keyHeld}, {3'b000, eHeld});
  endtask

  task automatic applyReset(input logic [3:0] raw);
    kprRaw = raw;
    resetN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAll("reset", 4'b1110, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    edgeNum = 0;
  endtask

  task automatic scanLoop(input string tag, input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(raw);
      checkAll(tag, cols[(edgeNum / 4) % 4], 4'b1111, 1'b0, 1'b0);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    edgeNum = 0;
    resetN  = 1'b0;
    kprRaw  = 4'b1111;
    cols[0] = 4'b1110;
    cols[1] = 4'b1101;
    cols[2] = 4'b1011;
    cols[3] = 4'b0111;

    // Press on column 1101 from reset, glitchy release, then a bouncing press on 1011.
    segTab[0]  = '{3,  4'b1111, 4'b1101 ^ 4'b0011, 4'b1111, 1'b0, 1'b0};
    segTab[1]  = '{1,  4'b1111, 4'b1101, 4'b1111, 1'b0, 1'b0};
    segTab[2]  = '{11, 4'b1011, 4'b1101, 4'b1111, 1'b0, 1'b0};
    segTab[3]  = '{1,  4'b1011, 4'b1101, 4'b1011, 1'b1, 1'b1};
    segTab[4]  = '{2,  4'b1011, 4'b1101, 4'b1011, 1'b0, 1'b1};
    segTab[5]  = '{5,  4'b1111, 4'b1101, 4'b1011, 1'b0, 1'b1};
    segTab[6]  = '{3,  4'b1011, 4'b1101, 4'b1011, 1'b0, 1'b1};
    segTab[7]  = '{10, 4'b1111, 4'b1101, 4'b1011, 1'b0, 1'b1};
    segTab[8]  = '{1,  4'b1111, 4'b1011, 4'b1111, 1'b0, 1'b0};
    segTab[9]  = '{5,  4'b1011, 4'b1011, 4'b1111, 1'b0, 1'b0};
    segTab[10] = '{1,  4'b1111, 4'b1011, 4'b1111, 1'b0, 1'b0};
    segTab[11] = '{13, 4'b1011, 4'b1011, 4'b1111, 1'b0, 1'b0};
    segTab[12] = '{1,  4'b1011, 4'b1011, 4'b1011, 1'b1, 1'b1};
    segTab[13] = '{3,  4'b1011, 4'b1011, 4'b1011, 1'b0, 1'b1};
    segTab[14] = '{0,  4'b1111, 4'b1110, 4'b1111, 1'b0, 1'b0};

    // Idle rows: columns walk every 4 cycles, nothing is ever reported.
    applyReset(4'b1111);
    scanLoop("idle", 4'b1111, 40);

    // Two rows low at once is rejected and scanning continues.
    applyReset(4'b1001);
    scanLoop("multi", 4'b1001, 40);

    applyReset(4'b1111);
    for (int s = 0; s < 14; s++) begin
      for (int c = 0; c < segTab[s].cycles; c++) begin
        applyStimulus(segTab[s].raw);
        checkAll($sformatf("seg%0d", s), segTab[s].expKpc, segTab[s].expKpr,
                 segTab[s].expValid, segTab[s].expHeld);
      end
    end

    // Reset asserted while HELD must clear outputs without waiting for a clock.
    #2;
    kprRaw = 4'b1111;
    resetN = 1'b0;
    #1;
    checkAll("async rst", 4'b1110, 4'b1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkAll("rst hold", 4'b1110, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    resetN  = 1'b1;
    edgeNum = 0;
    scanLoop("post rst", 4'b1111, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
